alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Front-panel controller for the 10-switch / 10-LED miniALU lab datapath.
- Walks the user through operand A, operand B and opcode entry on the switches, with one push-button step per entry.
- Issues a start/done handshake to an external miniALU and holds the result on the LEDs.
- Sits between the board I/O (switches, key) and the ALU instance.

Parameters:
- W, 5: operand width; operands come from switches[W-1:0]; 2*W must be ≤ 10.
- TIMEOUT, 16: maximum cycles spent in S_WAIT for alu_done before an error is flagged; must be ≥ 2.
- DEBOUNCE_CYCLES, 4: stability window for the key input; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- switches  input  10  board switches; level, quasi-static.
- key_next  input  1  push-button, active-high; asynchronous to clk.
- alu_a  output  W  operand A to the ALU.
- alu_b  output  W  operand B to the ALU.
- alu_op  output  2  opcode to the ALU: 00 add, 01 sub, 10 mul, 11 pass-A.
- alu_start  output  1  one-cycle request pulse.
- alu_done  input  1  one-cycle completion pulse from the ALU.
- alu_result  input  2*W  ALU result; valid in the cycle alu_done=1.
- leds  output  10  board LEDs; registered.
- state_dbg  output  3  current state encoding.
- err  output  1  high while showing a timed-out operation.

Behaviour:
- Everything is clocked on the rising edge of clk. rst is synchronous and active-high.
- Reset values: state=S_A, a_reg=0, b_reg=0, op_reg=0, res_reg=0, alu_start=0, err=0, leds=0, wait timer=0, synchronizer/edge flops=0.
- Key path:
  - key_next passes through a 2-flop synchronizer, then a rising-edge detector, producing key_evt (1 cycle).
  - Latency: if key_next is first sampled high at edge k, key_evt is high during the cycle after edge k+2, and the state changes at edge k+3.
  - A held key produces exactly one key_evt per press.
- Datapath outputs: alu_a=a_reg, alu_b=b_reg, alu_op=op_reg, driven continuously. They are stable from S_REQ through S_WAIT.
- States (state_dbg value):
  - S_A(0): leds<=switches. On key_evt: a_reg<=switches[W-1:0], go to S_B.
  - S_B(1): leds<=switches. On key_evt: b_reg<=switches[W-1:0], go to S_OP.
  - S_OP(2): leds<=switches. On key_evt: op_reg<=switches[1:0], go to S_REQ.
  - S_REQ(3): alu_start=1 for exactly this one cycle; timer<=0; go to S_WAIT unconditionally.
  - S_WAIT(4): alu_start=0.
    - If alu_done: res_reg<=alu_result, err<=0, go to S_SHOW.
    - Else if timer==TIMEOUT-1: res_reg<=0, err<=1, go to S_SHOW.
    - Else timer<=timer+1.
  - S_SHOW(5): leds<=zero-extended res_reg. On key_evt: err<=0, go to S_A.
- Encodings 6 and 7 are unreachable; if entered, go to S_A on the next edge.
- leds is registered: it reflects switches or res_reg one cycle later.
- Boundary rules:
  - key_evt in S_REQ or S_WAIT is dropped, not queued.
  - alu_done outside S_WAIT is ignored; results are never captured.
  - alu_done in the same cycle as the timeout: done wins (result captured, err=0).
  - alu_done in the first S_WAIT cycle (1 cycle after start) is accepted.
  - Reset mid-operation (any state) returns to S_A with alu_start=0 on the next edge. A late alu_done is ignored.
  - Switch changes outside a key_evt cycle never alter a_reg, b_reg or op_reg.

Optional Feature:
- Macro: ALU_SEQ_DEBOUNCE_EN.
- Defined:
  - A debounced level sits between the synchronizer and the edge detector.
  - It updates only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any reversion resets the count.
  - key_evt is generated on the debounced rising edge.
  - Pulses shorter than DEBOUNCE_CYCLES produce no event.
  - Added latency is DEBOUNCE_CYCLES cycles.
- Undefined:
  - Synchronizer output feeds the edge detector directly, with the latency defined above.
  - DEBOUNCE_CYCLES is unused.

Test Plan:
- Add sequence: switches 7, 3, 00 entered with one press each; ALU model pulses alu_done 2 cycles after alu_start with 10'd10 -> alu_start high exactly 1 cycle with alu_a=7, alu_b=3, alu_op=00; state_dbg=5; leds=10'd10; err=0.
- Timeout: same entry, ALU model never responds -> exactly TIMEOUT=16 cycles in S_WAIT, then state_dbg=5, err=1, leds=0. Next press -> state_dbg=0, err=0.
- Collision: press during S_WAIT is ignored; alu_done=1 with result 10'd21 on the timeout cycle -> leds=10'd21, err=0, state stays 5 until the next press.
- Reset in S_WAIT: rst high 1 cycle, then alu_done pulse with result 10'h3FF -> state_dbg=0, alu_start=0, res_reg unchanged at 0, leds echo switches.
- Held key: key_next high for 20 cycles in S_A with switches=5 -> exactly one transition to S_B, a_reg=5, no further advance.
- With ALU_SEQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 2-cycle key glitch produces no transition; a 10-cycle press produces one transition, DEBOUNCE_CYCLES cycles later than without the macro.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: front-panel sequencer for the miniALU lab board (A, B, opcode, start/done, show).
// Define ALU_SEQ_DEBOUNCE_EN to insert a key debouncer between the synchronizer and the edge detector.
module alu_op_sequencer #(
    parameter int W               = 5,
    parameter int TIMEOUT         = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       switches,
    input  logic             key_next,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [2*W-1:0]   alu_result,
    output logic [9:0]       leds,
    output logic [2:0]       state_dbg,
    output logic             err
);
    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_SHOW = 3'd5;
    localparam int TW = $clog2(TIMEOUT);

    if (TIMEOUT < 2 || 2 * W > 10 || W < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("alu_op_sequencer: illegal parameter set");
    end

    logic [2:0]     state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [2*W-1:0] res_q, res_d;
    logic           err_q, err_d;
    logic [9:0]     leds_q, leds_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           sync1_q, sync1_d, sync2_q, sync2_d;
    logic           prev_q, prev_d, key_evt_q, key_evt_d;
    logic           key_lvl;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic           deb_q, deb_d;
    logic [DW-1:0]  deb_cnt_q, deb_cnt_d;
`endif

    // Key path: 2-flop synchronizer, optional debounce, then a registered rising-edge detector.
    always_comb begin
        sync1_d = key_next;
        sync2_d = sync1_q;
`ifdef ALU_SEQ_DEBOUNCE_EN
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
            else                                       deb_cnt_d = deb_cnt_q + DW'(1);
        end
        key_lvl = deb_q;
`else
        key_lvl = sync2_q;
`endif
        prev_d    = key_lvl;
        key_evt_d = key_lvl & ~prev_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        leds_d  = leds_q;
        timer_d = timer_q;
        case (state_q)
            S_A: begin
                leds_d = switches;
                if (key_evt_q) begin
                    a_d     = switches[W-1:0];
                    state_d = S_B;
                end
            end
            S_B: begin
                leds_d = switches;
                if (key_evt_q) begin
                    b_d     = switches[W-1:0];
                    state_d = S_OP;
                end
            end
            S_OP: begin
                leds_d = switches;
                if (key_evt_q) begin
                    op_d    = switches[1:0];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            // A done arriving on the timeout cycle still wins.
            S_WAIT: begin
                if (alu_done) begin
                    res_d   = alu_result;
                    err_d   = 1'b0;
                    state_d = S_SHOW;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_SHOW;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SHOW: begin
                leds_d = 10'(res_q);
                if (key_evt_q) begin
                    err_d   = 1'b0;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            leds_q    <= '0;
            timer_q   <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            key_evt_q <= 1'b0;
`ifdef ALU_SEQ_DEBOUNCE_EN
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            err_q     <= err_d;
            leds_q    <= leds_d;
            timer_q   <= timer_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            key_evt_q <= key_evt_d;
`ifdef ALU_SEQ_DEBOUNCE_EN
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
`endif
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_start = (state_q == S_REQ);
    assign leds      = leds_q;
    assign state_dbg = state_q;
    assign err       = err_q;
endmodule
